// File: rtl/uart_transmitter_if.sv
// Byte handshake between a producer and the UART transmitter.
// A byte is transferred on any rising clk edge where tx_valid and tx_ready are both high.
interface uart_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises handshaked bytes LSB first as start / data / stop bits.
// The tx line is registered, and the baud counter is restarted on every state entry.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset,
  uart_transmitter_if.slave   bus,
  output logic                tx,
  output logic                transmitting,
  output logic                baud_tickt,
  output logic [15:0]         counter
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  state_t                 state, state_d;
  logic [15:0]            counter_d;
  logic [DATA_BITS-1:0]   shift, shift_d;
  logic [2:0]             bit_idx, bit_idx_d;
  logic                   tx_d;

  assign bus.tx_ready = (state == IDLE);
  assign transmitting = (state != IDLE);
  assign baud_tickt   = (state != IDLE) && (counter == LAST_CNT);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state;
    shift_d   = shift;
    bit_idx_d = bit_idx;
    tx_d      = 1'b1;
    counter_d = (state == IDLE || baud_tickt) ? 16'd0 : counter + 16'd1;

    case (state)
      IDLE: begin
        if (bus.tx_valid) begin
          state_d   = START;
          shift_d   = bus.tx_data[DATA_BITS-1:0];
          bit_idx_d = '0;
        end
      end
      START: begin
        if (baud_tickt) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (baud_tickt) begin
          shift_d = shift >> 1;
          if (bit_idx == LAST_DATA) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // bit_idx is reused to count stop-bit periods
        if (baud_tickt) begin
          if (bit_idx == LAST_STOP) state_d = IDLE;
          else                      bit_idx_d = bit_idx + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is derived from the next state so the registered line changes with the state
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      counter <= counter_d;
      shift   <= shift_d;
      bit_idx <= bit_idx_d;
      tx      <= tx_d;
    end
  end

endmodule
